// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//
// Shared definitions for the RISC-V pipeline front end and control path.
//   - NOP_INSTR      : canonical bubble instruction (addi x0, x0, 0)
//   - opcode_e       : the base opcodes recognised by control_unit
//   - aluop_e        : ALUOp encodings passed from control_unit to the ALU decoder
//   - instr_opcode() : extracts the 7-bit major opcode from an instruction word
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 7;

    // addi x0, x0, 0 -- architecturally a no-op, and its opcode (ALU_I) keeps
    // control_unit on a path with no memory or register side effects.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [OPCODE_W-1:0] {
        OPC_LOAD      = 7'b0000011,
        OPC_ALU_I     = 7'b0010011,
        OPC_STORE     = 7'b0100011,
        OPC_ALU_R     = 7'b0110011,
        OPC_BRANCH_EQ = 7'b1100011,
        OPC_JUMP      = 7'b1101111
    } opcode_e;

    // ADD for address generation (load/store/jump), SUB for branch compare,
    // FUNCT when the ALU decoder must look at funct3/funct7.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    function automatic logic [OPCODE_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch for the RISC-V pipeline. Owns the PC, drives a ROM with a
// one-cycle read latency and presents {instr, pc, valid} to the IF/ID boundary.
// Decode stalls are absorbed by a one-entry hold buffer; redirects (taken
// branch / jump) reload the PC and cost one bubble.
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   stall_id     in   decode cannot accept; keep outputs stable
//   redirect_en  in   load redirect_pc (wins over stall_id)
//   redirect_pc  in   redirect byte address, bits [1:0] ignored
//   imem_addr    out  ROM word address = pc_q[IMEM_ADDR_W+1:2]
//   imem_rdata   in   ROM data for the address presented last cycle
//   if_id_instr  out  instruction to decode (NOP when not valid)
//   if_id_pc     out  PC of if_id_instr
//   if_id_valid  out  if_id_instr is a real instruction
//   opcode       out  if_id_instr[6:0], to control_unit
// -----------------------------------------------------------------------------
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                IMEM_ADDR_W = 10,
    parameter logic [DATA_W-1:0] RESET_PC    = {DATA_W{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_id,
    input  logic                   redirect_en,
    input  logic [DATA_W-1:0]      redirect_pc,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0]      imem_rdata,
    output logic [DATA_W-1:0]      if_id_instr,
    output logic [DATA_W-1:0]      if_id_pc,
    output logic                   if_id_valid,
    output logic [6:0]             opcode
);

    // pc_q      : next address to request from the ROM
    // req_*_q   : instruction whose data is on imem_rdata (or in the buffer)
    // hold_*_q  : copy of imem_rdata taken on the first stalled edge, because
    //             the ROM output moves on to the next word while we wait
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] req_pc_q;
    logic              req_valid_q;
    logic [DATA_W-1:0] hold_instr_q;
    logic              hold_valid_q;

    logic [DATA_W-1:0] redirect_target;
    logic              redirect_lsb_unused;

    assign redirect_target     = {redirect_pc[DATA_W-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // ---- fetch request / IF-ID state ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            req_valid_q  <= 1'b0;
            hold_instr_q <= {DATA_W{1'b0}};
            hold_valid_q <= 1'b0;
        end else if (redirect_en) begin
            // The word arriving next cycle belongs to the old path; marking
            // the request invalid turns it into the bubble.
            pc_q         <= redirect_target;
            req_valid_q  <= 1'b0;
            hold_valid_q <= 1'b0;
        end else if (stall_id) begin
            // pc_q is held, so the ROM keeps re-reading the word after the
            // held one; on release that word lines up with req_pc_q <= pc_q.
            if (!hold_valid_q) begin
                hold_instr_q <= imem_rdata;
                hold_valid_q <= 1'b1;
            end
        end else begin
            pc_q         <= pc_q + DATA_W'(4);
            req_pc_q     <= pc_q;
            req_valid_q  <= 1'b1;
            hold_valid_q <= 1'b0;
        end
    end

    // ---- IF/ID outputs ----
    assign imem_addr = pc_q[IMEM_ADDR_W+1:2];

    always_comb begin
        if_id_instr = DATA_W'(NOP_INSTR);
        if (req_valid_q) begin
            if_id_instr = hold_valid_q ? hold_instr_q : imem_rdata;
        end
    end

    assign if_id_pc    = req_pc_q;
    assign if_id_valid = req_valid_q;
    assign opcode      = if_id_instr[6:0];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RISC-V pipeline, directly upstream of decode and of `control_unit`. Keeps the PC and drives a synchronous (1-cycle read latency) instruction ROM. Presents the fetched instruction, its PC and a valid flag to the IF/ID boundary; `opcode` feeds the control unit. Handles decode stalls with an internal hold buffer, and handles branch/jump redirects by inserting a bubble.

## Interface
- `DATA_W`, 32: instruction and PC width.
- `IMEM_ADDR_W`, 10: instruction ROM word-address width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `stall_id` in 1: decode cannot accept; hold the current output.
- `redirect_en` in 1: taken branch or jump; load `redirect_pc`.
- `redirect_pc` in DATA_W: redirect target byte address.
- `imem_addr` out IMEM_ADDR_W: ROM word address, `pc_q[IMEM_ADDR_W+1:2]`. Combinational.
- `imem_rdata` in DATA_W: ROM data; corresponds to the address presented on the previous cycle.
- `if_id_instr` out DATA_W: instruction to decode.
- `if_id_pc` out DATA_W: PC of `if_id_instr`.
- `if_id_valid` out 1: `if_id_instr` is a real instruction.
- `opcode` out 7: `if_id_instr[6:0]`, to the control unit.

## Operation
- **State registers**
  - `pc_q`: next address to request.
  - `req_pc_q`, `req_valid_q`: the in-flight/output instruction.
  - `hold_instr_q`, `hold_valid_q`: stall buffer.
- **Output mux**
  - `if_id_instr` is `hold_instr_q` if `hold_valid_q`, else `imem_rdata`.
  - When `req_valid_q`=0, `if_id_instr` is forced to NOP `32'h0000_0013` (`opcode` = 7'b0010011).
  - `if_id_pc` = `req_pc_q`; `if_id_valid` = `req_valid_q`.
- **Priority per cycle:** `rst` > `redirect_en` > `stall_id` > advance.
- **Advance:**
  - `pc_q` <= `pc_q`+4, wrapping modulo 2^DATA_W.
  - `req_pc_q` <= `pc_q`; `req_valid_q` <= 1; `hold_valid_q` <= 0.
- **Stall (no redirect):**
  - `pc_q`, `req_pc_q` and `req_valid_q` hold.
  - If `hold_valid_q`=0: `hold_instr_q` <= `imem_rdata` and `hold_valid_q` <= 1.
  - If `hold_valid_q`=1: the buffer is untouched.
  - Outputs are bit-stable for the whole stall.
- **Redirect** (also while stalled):
  - `pc_q` <= {`redirect_pc[DATA_W-1:2]`, 2'b00}; target bits [1:0] are ignored.
  - `req_valid_q` <= 0; `hold_valid_q` <= 0.
  - The wrong-path instruction returned next cycle is discarded.
- **Stall release:** the last stalled cycle still outputs from the buffer. Because the ROM re-read the held `pc_q` throughout the stall, the next advance pairs `req_pc_q` <= `pc_q` with the matching `imem_rdata`.

## Timing
- **Reset values:**
  - Registers: `pc_q`=`RESET_PC`, `req_pc_q`=`RESET_PC`, `req_valid_q`=0, `hold_valid_q`=0, `hold_instr_q`=0.
  - Outputs: `if_id_valid`=0, `if_id_instr`=`32'h13`, `opcode`=7'h13, `if_id_pc`=`RESET_PC`, `imem_addr`=`RESET_PC[IMEM_ADDR_W+1:2]`.
- **After reset:** first edge with `rst`=0 → `if_id_valid`=1, `if_id_pc`=`RESET_PC`, `if_id_instr`=mem[`RESET_PC`>>2].
- **Throughput and latency:** 1 instruction/cycle. Address-to-output latency is 1 cycle.
- **Redirect penalty:** edge N samples `redirect_en`; the cycle after N is a bubble (valid=0). The target instruction is valid after edge N+1.
- **Reset mid-stall or mid-redirect:** reset wins and all state is reinitialised; no buffered instruction survives.
- **Combinational paths:** `imem_addr` depends only on `pc_q`. No combinational path from `stall_id`/`redirect_en` to any output.

## Structure
- Shared package `cpu_pkg` holds:
  - the NOP constant `32'h0000_0013`;
  - the RISC-V opcode constants (ALU_R, ALU_I, BRANCH_EQ, JUMP, LOAD, STORE), reused by `control_unit`;
  - the ALUOp encodings.
- One module, no sub-module: the hold buffer is two registers and a mux.

## Test plan
- **Reset then free-run** (ROM[i] = 32'h100+i, `RESET_PC`=0): after reset, outputs are PC 0,4,8,… and instr 0x100,0x101,0x102 on consecutive cycles. `if_id_valid` is 0 only during reset.
- **3-cycle stall while PC 8 is output:** `if_id_pc`=8 and `if_id_instr`=0x102 are held for 3 cycles. The next cycle outputs PC 12 / 0x103, with no skip and no duplicate.
- **Redirect to 0x40 at PC 4:** the next cycle has `if_id_valid`=0 and `opcode`=7'h13. The following cycle has PC 0x40 / instr 0x110.
- **Redirect asserted during stall** (`redirect_pc`=0x23): the stall buffer is dropped, one bubble follows, then PC 0x20 / 0x108 (low bits cleared).
- **Wrap:** with `RESET_PC`=32'hFFFF_FFFC and an 8-bit ROM, the sequence is FFFF_FFFC → 0000_0000 → 0000_0004.
- **`rst` asserted mid-stall:** the next cycle has valid=0. After release, the output restarts at `RESET_PC` with the correct instruction.
